// File: rtl/log_frame_sequencer_pkg.sv
// Shared constants and FSM encoding for the mel log stage.
package mel_pkg;

    localparam int unsigned NBIN      = 64;
    localparam int unsigned BIN_IDX_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/log_frame_sequencer_log_unit.sv
// Combinational log approximation: ((bit_length(x) + SHIFT) * 5) / 7.
module log_unit #(
    parameter int unsigned I_BW  = 30,
    parameter int unsigned O_BW  = 14,
    parameter int unsigned SHIFT = 10
) (
    input  logic [I_BW-1:0] i_x,
    output logic [O_BW-1:0] o_y
);

    localparam int unsigned L_W = $clog2(I_BW + 1);
    localparam int unsigned P_W = 16;

    logic [L_W-1:0] w_len;
    logic [P_W-1:0] w_sum;
    logic [P_W-1:0] w_prod;

    // Priority encoder: highest set bit wins, zero input gives length 0.
    always_comb begin
        w_len = '0;
        for (int i = 0; i < int'(I_BW); i++) begin
            if (i_x[i]) begin
                w_len = L_W'(i + 1);
            end
        end
    end

    assign w_sum  = P_W'(w_len) + P_W'(SHIFT);
    assign w_prod = w_sum * P_W'(5);
    assign o_y    = O_BW'(w_prod / P_W'(7));

endmodule

// File: rtl/log_frame_sequencer.sv
// Frame-level sequencer: latches a mel frame, runs one shared log unit per bin, presents results.
module log_frame_sequencer
    import mel_pkg::*;
#(
    parameter int unsigned I_BW  = 30,
    parameter int unsigned O_BW  = 14,
    parameter int unsigned SHIFT = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [I_BW*NBIN-1:0]   data_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [O_BW*NBIN-1:0]   data_o,
    output logic                   busy,
    output logic [BIN_IDX_W-1:0]   bin_idx
);

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_busy;
    logic [BIN_IDX_W-1:0]   r_bin_idx;
    logic [I_BW*NBIN-1:0]   r_in_buf;
    logic [O_BW*NBIN-1:0]   r_data_o;

    logic [I_BW-1:0]        w_bin;
    logic [O_BW-1:0]        w_log;

    // Indexed read mux feeding the single shared log unit.
    assign w_bin = r_in_buf[r_bin_idx*I_BW +: I_BW];

    log_unit #(
        .I_BW  (I_BW),
        .O_BW  (O_BW),
        .SHIFT (SHIFT)
    ) u_log_unit (
        .i_x (w_bin),
        .o_y (w_log)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_bin_idx   <= '0;
            r_in_buf    <= '0;
            r_data_o    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_state    <= ST_RUN;
                        r_in_buf   <= data_i;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_bin_idx  <= '0;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_data_o[r_bin_idx*O_BW +: O_BW] <= w_log;
                    // Last bin ends the pass; the counter is cleared rather than wrapped.
                    if (r_bin_idx == BIN_IDX_W'(NBIN - 1)) begin
                        r_state     <= ST_DONE;
                        r_bin_idx   <= '0;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_bin_idx <= r_bin_idx + BIN_IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // in_ready rises with the handoff, so no frame is taken on this edge.
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_bin_idx   <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign bin_idx   = r_bin_idx;
    assign data_o    = r_data_o;

endmodule
